// File: rtl/fsm_seq_gen_pkg.sv
// Shared state encoding and default sizing for the serial pattern transmitter.
package fsm_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 3;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/fsm_seq_gen_piso_shift.sv
// Parallel-load, shift-left register; msb is the bit the transmitter emits next.
module piso_shift #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times,
// with optional idle gaps, under a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; all outputs low
//   SHIFT | pattern bit on dout, dvalid high
//   GAP   | idle gap between repetitions
//   DONE  | one-cycle done pulse, busy still high
module fsm_seq_gen
    import fsm_seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] reps_left;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gap_cnt;
    logic [IW-1:0]    bit_idx;

    logic             last_bit;
    logic             rep_more;
    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_din;
    logic             sr_msb;

    assign last_bit = (bit_idx == '0);
    assign rep_more = (reps_left != CNT_W'(1));

    // The current bit is driven straight into dout, so the shifter is loaded
    // with the remaining bits already aligned at its msb.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = {pat_q[PAT_W-2:0], 1'b0};
        case (state)
            IDLE: begin
                sr_load = start && (reps != '0);
                sr_din  = {pattern[PAT_W-2:0], 1'b0};
            end
            SHIFT: begin
                sr_shift = !last_bit;
                sr_load  = last_bit && rep_more && (gap_q == '0);
            end
            GAP: begin
                sr_load = (gap_cnt == '0);
            end
            default: ;
        endcase
    end

    piso_shift #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            reps_left <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            bit_idx   <= '0;
            dout      <= 1'b0;
            dvalid    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout   <= 1'b0;
                    dvalid <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        pat_q     <= pattern;
                        reps_left <= reps;
                        gap_q     <= gap;
                        if (reps != '0) begin
                            dout    <= pattern[PAT_W-1];
                            dvalid  <= 1'b1;
                            bit_idx <= IW'(PAT_W - 1);
                            state   <= SHIFT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        dout    <= sr_msb;
                        bit_idx <= bit_idx - IW'(1);
                    end else begin
                        reps_left <= reps_left - CNT_W'(1);
                        if (!rep_more) begin
                            dout   <= 1'b0;
                            dvalid <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (gap_q != '0) begin
                            dout    <= 1'b0;
                            dvalid  <= 1'b0;
                            gap_cnt <= gap_q - CNT_W'(1);
                            state   <= GAP;
                        end else begin
                            dout    <= pat_q[PAT_W-1];
                            bit_idx <= IW'(PAT_W - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        dout    <= pat_q[PAT_W-1];
                        dvalid  <= 1'b1;
                        bit_idx <= IW'(PAT_W - 1);
                        state   <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    dout   <= 1'b0;
                    dvalid <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: expected per-cycle output records are queued
// at stimulus time and compared by a monitor on every busy cycle.
module tb_fsm_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] pattern;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       dout;
    logic       dvalid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int det_cnt = 0;
    logic [2:0] hist = '0;
    logic [3:0] exp_q[$];

    fsm_seq_gen #(.PAT_W(3), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .gap     (gap),
        .dout    (dout),
        .dvalid  (dvalid),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: busy/dvalid/dout/done got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every busy cycle consumes one expected record; idle cycles must be quiet.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [2:0] nh;
        if (rst) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_busy: got busy=1 expected no pending transfer at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("cycle", {busy, dvalid, dout, done}, e);
                end
            end else begin
                check("idle", {busy, dvalid, dout, done}, 4'b0000);
            end
            nh = {hist[1:0], dvalid & dout};
            if (nh == 3'b111) det_cnt++;
            hist = nh;
        end
    end

    task automatic push_expected(input logic [2:0] p, input int r, input int g);
        for (int k = 0; k < r; k++) begin
            for (int i = 2; i >= 0; i--) exp_q.push_back({1'b1, 1'b1, p[i], 1'b0});
            if (k < r - 1)
                for (int j = 0; j < g; j++) exp_q.push_back(4'b1000);
        end
        exp_q.push_back(4'b1001);
    endtask

    // now=1: start is raised during the DONE cycle and held so it lands on the
    // first IDLE edge (minimum turnaround).
    task automatic send(input logic [2:0] p, input logic [3:0] r, input logic [3:0] g, input bit now);
        if (!now) @(negedge clk);
        push_expected(p, int'(r), int'(g));
        pattern = p;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(negedge clk);
        if (now) @(negedge clk);
        start   = 1'b0;
        pattern = ~p;
        reps    = r + 4'd3;
        gap     = g + 4'd1;
    endtask

    task automatic wait_drain(input bit keep_done_cycle);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && (keep_done_cycle || !busy)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d records pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        start = 1'b0; pattern = '0; reps = '0; gap = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check("reset_state", {busy, dvalid, dout, done}, 4'b0000);
        #9 rst = 1'b1;

        send(3'b111, 4'd1, 4'd0, 1'b0);
        wait_drain(1'b0);

        send(3'b101, 4'd2, 4'd2, 1'b0);
        wait_drain(1'b0);

        det_cnt = 0;
        send(3'b111, 4'd3, 4'd0, 1'b0);
        wait_drain(1'b0);
        total++;
        if (det_cnt != 7) begin
            bad++;
            $display("FAIL loopback_111: got %0d detections expected 7", det_cnt);
        end

        send(3'b011, 4'd0, 4'd0, 1'b0);
        wait_drain(1'b1);
        send(3'b100, 4'd2, 4'd1, 1'b1);
        wait_drain(1'b0);

        send(3'b101, 4'd2, 4'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pattern = 3'b010; reps = 4'd5; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(1'b0);

        send(3'b110, 4'd2, 4'd0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", {busy, dvalid, dout, done}, 4'b0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", {busy, dvalid, dout, done}, 4'b0000);

        send(3'b010, 4'd1, 4'd3, 1'b0);
        wait_drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_seq_gen.md
Name: fsm_seq_gen

Overview:
- Serial pattern transmitter FSM. It drives a programmable PAT_W-bit pattern MSB-first onto a 1-bit line, repeated a programmable number of times, with optional idle gaps between repetitions.
- It is the stimulus/transmit end for the team's serial sequence detectors; dout connects directly to a detector's din.
- It uses a start/busy/done handshake toward the controlling logic.

Parameters:
- PAT_W, 3, pattern length in bits (>=2).
- CNT_W, 4, width of the repetition and gap counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- start  input  1  request to transmit; sampled only in IDLE.
- pattern  input  PAT_W  bit pattern, transmitted MSB first.
- reps  input  CNT_W  number of pattern repetitions; 0 means none.
- gap  input  CNT_W  idle cycles inserted between consecutive repetitions.
- dout  output  1  serial data bit.
- dvalid  output  1  high while dout carries a pattern bit.
- busy  output  1  high from the accepting edge through the last DONE cycle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, dout=0, dvalid=0, busy=0, done=0, counters=0.
- States are IDLE, SHIFT, GAP and DONE. Encodings are in the package; unreachable encodings go to IDLE with all outputs 0.
- IDLE: dout=0, dvalid=0, busy=0.
  - On an edge with start=1 and reps!=0: latch pattern, reps and gap. Load the shift register. Drive dout<=pattern[PAT_W-1], dvalid<=1, busy<=1. Go to SHIFT.
  - On an edge with start=1 and reps==0: busy<=1, go to DONE. No bits are sent.
- SHIFT: one bit per cycle, MSB first; exactly PAT_W consecutive dvalid cycles per repetition.
  - After the last bit of a repetition, decrement the remaining-reps count.
  - If reps remain and gap!=0: go to GAP.
  - If reps remain and gap==0: reload the pattern back-to-back with no bubble.
  - If no reps remain: go to DONE.
- GAP: dout=0, dvalid=0 for exactly gap cycles. Then reload the pattern and return to SHIFT; the first bit appears on the cycle after the last gap cycle.
- DONE: done=1 and busy=1 for exactly one cycle; dout=0, dvalid=0. Then go to IDLE.
  - A new start is accepted on the first IDLE edge after DONE, so the minimum turnaround is 1 idle cycle.
- Latency: for start accepted at edge k, bit i (0=MSB) of repetition 0 is on dout in the cycle after edge k+i.
  - Total active cycles = reps*PAT_W + (reps-1)*gap, followed by the DONE cycle.
- start while busy=1 is ignored. pattern, reps and gap changes after acceptance have no effect (inputs are latched).
- Counter widths:
  - Bit index counter: clog2(PAT_W) bits.
  - reps/gap counters: CNT_W bits.
  - No wrap-around is possible because counters only decrement from the latched value to 0.
- Reset mid-operation (any state): outputs drop to 0 asynchronously and state returns to IDLE. No done pulse is issued. After rst returns to 1, the block waits for a fresh start.

Decomposition:
- Package fsm_seq_gen_pkg holds:
  - State localparams IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3.
  - Default PAT_W/CNT_W constants.
- One sub-module, piso_shift: a parallel-load, shift-left register with load, shift and msb outputs, on the same asynchronous active-low rst. It owns the data path; the FSM, counters and handshake stay in fsm_seq_gen.

Test Plan:
- pattern=3'b111, reps=1, gap=0, start pulse -> dout=1,1,1 with dvalid=1 for 3 cycles; done=1 on the 4th cycle; busy high for 4 cycles.
- pattern=3'b101, reps=2, gap=2 -> dout/dvalid sequence 1/1, 0/1, 1/1, 0/0, 0/0, 1/1, 0/1, 1/1, then done pulse; exactly 8 active cycles.
- Loopback into the "111" detector: pattern=3'b111, reps=3, gap=0 -> 9 consecutive dvalid ones, no bubble; the detector asserts on 7 consecutive cycles (overlapping detection).
- reps=0, start=1 -> dvalid never asserts; done=1 on the cycle after the accepting edge; busy high for 1 cycle.
- start re-asserted mid-SHIFT with a different pattern -> ignored; the original sequence completes unchanged; only one done pulse.
- rst=0 asserted between clock edges during SHIFT -> dout, dvalid and busy go to 0 without waiting for an edge; no done pulse. After rst=1 with start held low, the block stays in IDLE.
